ram_dp_be: RTL
==============

// Module: ram_dp_be
// PURPOSE
//  Parametrised simple dual-port RAM (1 write port, 1 read port) with byte enables.
//  Registered read with valid flag; same-address read-during-write returns the new data.
//  Built-in clear sequencer zeroes every word after reset or on request.
//  General-purpose on-chip storage for datapath buffers and register files.
// PARAMETERS
//  N   6   address width; depth = 2**N words
//  M   32  data width in bits; must be a multiple of BW
//  BW  8   byte-lane width in bits; NB = M/BW lanes
// PORTS
//  clk     in   1      single clock; all state updates on posedge
//  rst_n   in   1      asynchronous, active-low reset
//  clr     in   1      clear request (1-cycle pulse, sampled only when busy=0)
//  we      in   1      write enable
//  wadr    in   N      write address
//  be      in   NB     byte-lane write enables; lane i = din[i*BW +: BW]
//  din     in   M      write data
//  re      in   1      read enable
//  radr    in   N      read address
//  dout    out  M      registered read data
//  dvalid  out  1      dout updated this cycle (1-cycle pulse per accepted read)
//  busy    out  1      clear sequencer active; port accesses are dropped
// BEHAVIOUR
//  - Reset (async on rst_n low): state=CLEAR, cnt=0, busy=1, dout=0, dvalid=0.
//    Array contents are not reset directly; the sequencer zeroes them.
//  - CLEAR: each posedge writes 0 to mem[cnt]; cnt increments.
//    The edge that writes cnt=2**N-1 moves to RUN, sets busy=0 and cnt=0.
//    Busy therefore falls after exactly 2**N edges following reset release.
//  - In CLEAR, we and re are ignored: no array write, dvalid=0, dout holds.
//  - RUN, write: if we=1, then mem[wadr] lane i <= din lane i for every be[i]=1.
//    Lanes with be[i]=0 are unchanged. we=1 with be=0 is a no-op.
//  - RUN, read: re=1 at edge t gives dout=mem[radr] and dvalid=1 after edge t (latency 1).
//    re=0 gives dvalid=0 and dout holds its last value.
//  - Read-during-write, same address, same edge (write-first): dout lane i = din lane i
//    if be[i]=1, else the old mem lane. Different addresses do not interact.
//  - clr=1 in RUN: next edge enters CLEAR (cnt=0, busy=1).
//    The we and re of that same cycle are dropped (dvalid=0).
//  - clr while busy=1 is ignored; the clear sequence does not restart.
//  - rst_n asserted mid-CLEAR or mid-RUN: immediate return to reset state.
//    Clearing restarts from address 0.
//  - Addresses are always in range (2**N words); no wrap logic beyond cnt rollover to 0.
// STRUCTURE
//  - Package ram_pkg: typedef enum logic {CLEAR, RUN} ram_state_t.
//    Also holds the helper function lane_merge(old, new, be) used by the array write
//    and by forwarding.
//  - Sub-module ram_clr_seq: FSM plus N-bit counter.
//    Outputs busy, clr_we, clr_adr. Top muxes clr_adr/zero data onto the write port
//    while busy=1.
//  - Top: array logic [M-1:0] mem [2**N-1:0], write mux, forwarding, dout/dvalid regs.
// TESTING (N=6, M=32, BW=8)
//  - Reset release: busy=1 for 64 edges then 0. Read each of adr 0..63:
//    each returns 32'h0 with dvalid=1 one cycle after re.
//  - Write adr 5 = 32'hDEADBEEF, be=4'hF; then write adr 5 din=32'h11223344, be=4'b0101.
//    Read adr 5: returns 32'hDE22BE44.
//  - Same edge: we=1, wadr=9, din=32'hCAFEF00D, be=4'b1100; re=1, radr=9 (old value 0).
//    dout=32'hCAFE0000, dvalid=1. Back-to-back re reads a new adr every cycle:
//    dvalid stays high.
//  - Fill adr 0..63 with nonzero data, pulse clr together with we/re.
//    The write is dropped and dvalid=0, busy=1 for 64 edges, then all reads return 0.
//  - Pull rst_n low after 20 edges of CLEAR: dout=0, dvalid=0 at once.
//    After release, busy stays high a full 64 edges.
//  - clr pulse while busy=1: ignored, busy falls on the original schedule.
//    we/re while busy: no write, dvalid=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
// lane_merge works on a fixed maximum width so one function serves any
// instance; callers widen their operands and narrow the result.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  // Widest data word lane_merge can handle, and the index width for that word.
  localparam int unsigned LM_MAX_W = 256;
  localparam int unsigned LM_IDX_W = 8;

  // Take each bit from new_w when its byte lane is enabled, else from old_w.
  function automatic logic [LM_MAX_W-1:0] lane_merge(
    input logic [LM_MAX_W-1:0] old_w,
    input logic [LM_MAX_W-1:0] new_w,
    input logic [LM_MAX_W-1:0] be,
    input int unsigned         bw
  );
    logic [LM_MAX_W-1:0] res;
    int unsigned         lane;
    res = old_w;
    for (int unsigned b = 0; b < LM_MAX_W; b++) begin
      lane = (bw == 32'd0) ? b : (b / bw);
      if (be[LM_IDX_W'(lane)]) begin
        res[LM_IDX_W'(b)] = new_w[LM_IDX_W'(b)];
      end else begin
        res[LM_IDX_W'(b)] = old_w[LM_IDX_W'(b)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dp_be_if.sv
// Port bundle of the byte-enabled dual-port RAM: write port, read port,
// clear request and status.
interface ram_dp_be_if #(
  parameter int unsigned N  = 6,
  parameter int unsigned M  = 32,
  parameter int unsigned BW = 8
);
  localparam int unsigned NB = M / BW;

  logic          clr;
  logic          we;
  logic [N-1:0]  wadr;
  logic [NB-1:0] be;
  logic [M-1:0]  din;
  logic          re;
  logic [N-1:0]  radr;
  logic [M-1:0]  dout;
  logic          dvalid;
  logic          busy;

  modport master (
    output clr, we, wadr, be, din, re, radr,
    input  dout, dvalid, busy
  );

  modport slave (
    input  clr, we, wadr, be, din, re, radr,
    output dout, dvalid, busy
  );
endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: after reset or a clear request it walks every address
// once, asking the top to write zero there, then hands the RAM to the user.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic         busy,
  output logic         clr_we,
  output logic [N-1:0] clr_adr
);

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  ram_state_t   state_r;
  ram_state_t   state_nxt_s;
  logic [N-1:0] cnt_r;
  logic [N-1:0] cnt_nxt_s;
  logic         busy_r;

  // State, address counter and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CLEAR;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == CLEAR);
    end
  end

  // Next state: sweep all addresses in CLEAR; a clear request in RUN restarts the sweep.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == CNT_MAX) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (clr) begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = CLEAR;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  assign busy    = busy_r;
  assign clr_we  = busy_r;
  assign clr_adr = cnt_r;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-lane write enables, registered write-first
// read with a valid pulse, and a built-in zeroing sweep after reset or clear.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int unsigned N  = 6,
  parameter int unsigned M  = 32,
  parameter int unsigned BW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_dp_be_if.slave   bus
);

  localparam int unsigned NB    = M / BW;
  localparam int unsigned DEPTH = 2 ** N;

  logic         busy_s;
  logic         clr_we_s;
  logic [N-1:0] clr_adr_s;

  logic         wr_en_s;
  logic [N-1:0] wr_adr_s;
  logic [M-1:0] wr_data_s;
  logic         rd_en_s;
  logic [M-1:0] rd_data_s;

  logic [M-1:0] mem_r [DEPTH];
  logic [M-1:0] dout_r;
  logic         dvalid_r;

  // Byte-lane merge at this instance's width.
  function automatic logic [M-1:0] merge_word(
    input logic [M-1:0]  old_w,
    input logic [M-1:0]  new_w,
    input logic [NB-1:0] be_w
  );
    return M'(lane_merge(LM_MAX_W'(old_w), LM_MAX_W'(new_w), LM_MAX_W'(be_w), BW));
  endfunction

  ram_clr_seq #(
    .N (N)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.clr),
    .busy    (busy_s),
    .clr_we  (clr_we_s),
    .clr_adr (clr_adr_s)
  );

  // Write-port mux: the sweep owns the port while busy; a clear request drops user accesses.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_adr_s  = {N{1'b0}};
    wr_data_s = {M{1'b0}};
    rd_en_s   = 1'b0;
    if (clr_we_s) begin
      wr_en_s  = 1'b1;
      wr_adr_s = clr_adr_s;
    end else if (bus.clr) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s   = bus.we;
      wr_adr_s  = bus.wadr;
      wr_data_s = merge_word(mem_r[bus.wadr], bus.din, bus.be);
      rd_en_s   = bus.re;
    end
  end

  // Read data with write-first forwarding when both ports hit the same word.
  always_comb begin
    rd_data_s = mem_r[bus.radr];
    if (wr_en_s && (wr_adr_s == bus.radr)) begin
      rd_data_s = wr_data_s;
    end else begin
      rd_data_s = mem_r[bus.radr];
    end
  end

  // Storage array; contents are zeroed by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_adr_s] <= wr_data_s;
    end
  end

  // Registered read data and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r   <= {M{1'b0}};
      dvalid_r <= 1'b0;
    end else if (rd_en_s) begin
      dout_r   <= rd_data_s;
      dvalid_r <= 1'b1;
    end else begin
      dvalid_r <= 1'b0;
    end
  end

  assign bus.dout   = dout_r;
  assign bus.dvalid = dvalid_r;
  assign bus.busy   = busy_s;

endmodule
